// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with 2-entry skid buffer
// Optional macro: ID_EX_STAGE_PERF_EN adds perf_stall_cnt / perf_flush_cnt.
module id_ex_stage_reg #(
  parameter int XLEN  = 64,
  parameter int OP_W  = 8,
  parameter int ALU_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [OP_W-1:0]  in_op_info,
  input  logic [ALU_W-1:0] in_alu_info,
  input  logic             in_is_word,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_wen,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [OP_W-1:0]  out_op_info,
  output logic [ALU_W-1:0] out_alu_info,
  output logic             out_is_word,
  output logic [4:0]       out_rd,
  output logic             out_rd_wen
`ifdef ID_EX_STAGE_PERF_EN
  ,
  output logic [63:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  localparam int PW = 3*XLEN + OP_W + ALU_W + 7;

  // Occupancy encoded as {S.valid, M.valid}; S is only ever valid behind M.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;

  logic          r_m_valid;
  logic          r_s_valid;
  logic [PW-1:0] r_m_data;
  logic [PW-1:0] r_s_data;

  logic [PW-1:0] w_in_data;
  logic [PW-1:0] w_out_data;
  logic [1:0]    w_state;
  logic          w_in_fire;
  logic          w_out_fire;

  assign w_in_data  = {in_pc, in_op1, in_op2, in_op_info, in_alu_info,
                       in_is_word, in_rd, in_rd_wen};
  assign w_state    = {r_s_valid, r_m_valid};

  // in_ready depends only on held state (and reset), never on out_ready.
  assign in_ready   = rst & ~r_s_valid;
  assign out_valid  = r_m_valid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_m_valid & out_ready;

  // Payload is zeroed whenever M is empty so EX never sees stale data.
  assign w_out_data = r_m_valid ? r_m_data : '0;
  assign {out_pc, out_op1, out_op2, out_op_info, out_alu_info,
          out_is_word, out_rd, out_rd_wen} = w_out_data;

  // Skid-buffer state machine: flush empties everything, otherwise FIFO order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= '0;
      r_s_data  <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_m_data  <= w_in_data;
            r_m_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_m_data <= w_in_data;
          end else if (w_in_fire) begin
            r_s_data  <= w_in_data;
            r_s_valid <= 1'b1;
          end else if (w_out_fire) begin
            r_m_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            r_m_data  <= r_s_data;
            r_s_valid <= 1'b0;
          end
        end
        default: begin
          r_m_valid <= r_m_valid;
          r_s_valid <= r_s_valid;
        end
      endcase
    end
  end

`ifdef ID_EX_STAGE_PERF_EN
  logic [63:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;

  // Stall = EX holding a valid op it cannot consume; flush counted only when it kills something.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_m_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 64'd1;
      if (flush && (r_m_valid || r_s_valid || w_in_fire)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
